// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative IEEE-754 single-precision divider, s = a / b, with 2-bit rounding mode.
// Latency: 28 cycles after the accepting edge for finite nonzero operands, 2 cycles for specials.
// Backpressure: start is sampled only in IDLE; busy flags an in-flight divide, done pulses once.
// Ports: clk, rst (async, active-high) | start, a, b, rm in | busy, done, s out.
module fdiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    output logic        busy,
    output logic        done,
    output logic [31:0] s
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIV   = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Leading-zero count of a 24-bit significand (24 for an all-zero input).
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++)
            if (v[i]) n = 5'(23 - i);
        return n;
    endfunction

    logic [1:0]        r_state;
    logic              r_sign;
    logic [1:0]        r_rm;
    logic              r_special;
    logic [31:0]       r_spec_val;
    logic [23:0]       r_div;
    logic [24:0]       r_rem;
    logic [25:0]       r_q;
    logic [4:0]        r_cnt;
    logic signed [9:0] r_exp;
    logic [31:0]       r_s;

    // ---------------- operand decode at capture ----------------
    logic [7:0]        w_ea, w_eb;
    logic [22:0]       w_fa, w_fb;
    logic              w_sign_in;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [4:0]        w_lz_a, w_lz_b;
    logic [23:0]       w_ma, w_mb;
    logic signed [9:0] w_xa, w_xb, w_exp_raw;
    logic              w_a_lt;
    logic              w_special;
    logic [31:0]       w_spec_val;

    assign w_ea      = a[30:23];
    assign w_eb      = b[30:23];
    assign w_fa      = a[22:0];
    assign w_fb      = b[22:0];
    assign w_sign_in = a[31] ^ b[31];
    assign w_a_nan   = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan   = (w_eb == 8'hFF) && (w_fb != 23'd0);
    assign w_a_inf   = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf   = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_a_zero  = (w_ea == 8'h00) && (w_fa == 23'd0);
    assign w_b_zero  = (w_eb == 8'h00) && (w_fb == 23'd0);

    // Normals already have the hidden bit at the top (lz = 0); denormals are shifted up
    // and their exponent becomes 1 - lz so the divide always sees a normalized significand.
    assign w_lz_a    = lzc24({|w_ea, w_fa});
    assign w_lz_b    = lzc24({|w_eb, w_fb});
    assign w_ma      = {|w_ea, w_fa} << w_lz_a;
    assign w_mb      = {|w_eb, w_fb} << w_lz_b;
    assign w_xa      = (w_ea == 8'h00) ? 10'sd1 - $signed({5'd0, w_lz_a}) : $signed({2'd0, w_ea});
    assign w_xb      = (w_eb == 8'h00) ? 10'sd1 - $signed({5'd0, w_lz_b}) : $signed({2'd0, w_eb});
    assign w_exp_raw = w_xa - w_xb + 10'sd127;
    // Pre-doubling a smaller dividend guarantees the first quotient bit is 1.
    assign w_a_lt    = w_ma < w_mb;

    always_comb begin
        w_special  = 1'b1;
        w_spec_val = 32'd0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
            w_spec_val = 32'hFFC00000;
        else if (w_b_zero || w_a_inf)
            w_spec_val = {w_sign_in, 8'hFF, 23'd0};
        else if (w_a_zero || w_b_inf)
            w_spec_val = {w_sign_in, 31'd0};
        else
            w_special = 1'b0;
    end

    // ---------------- restoring divide step ----------------
    logic [24:0] w_divx, w_part, w_rem_nxt;
    logic        w_ge;

    assign w_divx    = {1'b0, r_div};
    assign w_ge      = r_rem >= w_divx;
    assign w_part    = w_ge ? r_rem - w_divx : r_rem;
    assign w_rem_nxt = w_part << 1;   // w_part < divisor < 2^24, so the dropped MSB is zero

    // ---------------- rounding ----------------
    logic [26:0]       w_frac0, w_frac_sh, w_frac1;
    logic              w_sub, w_lost;
    logic [9:0]        w_sh_full;
    logic [4:0]        w_sh;
    logic              w_g, w_r, w_st, w_lsb, w_inc, w_to_inf, w_ovf;
    logic [24:0]       w_sum;
    logic signed [9:0] w_exp_fin;
    logic [31:0]       w_result;

    assign w_frac0   = {r_q, |r_rem};
    assign w_sub     = r_exp <= 10'sd0;
    assign w_sh_full = 10'(10'sd1 - r_exp);
    // Beyond 26 every quotient bit is already in the sticky position.
    assign w_sh      = (w_sh_full > 10'd26) ? 5'd26 : w_sh_full[4:0];
    assign w_frac_sh = w_frac0 >> w_sh;
    assign w_lost    = |(w_frac0 & ~(27'h7FFFFFF << w_sh));
    assign w_frac1   = w_sub ? {w_frac_sh[26:1], w_frac_sh[0] | w_lost} : w_frac0;

    assign w_lsb = w_frac1[3];
    assign w_g   = w_frac1[2];
    assign w_r   = w_frac1[1];
    assign w_st  = w_frac1[0];

    always_comb begin
        w_inc = 1'b0;
        case (r_rm)
            2'b00:   w_inc = w_g & (w_r | w_st | w_lsb);
            2'b01:   w_inc = (w_g | w_r | w_st) & r_sign;
            2'b10:   w_inc = (w_g | w_r | w_st) & ~r_sign;
            default: w_inc = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_frac1[26:3]} + {24'd0, w_inc};
    // Subnormal path: a round-up into bit 23 lands on exponent 1 (the smallest normal).
    // Normal path: a carry out of bit 23 leaves an all-zero fraction and bumps the exponent.
    assign w_exp_fin = w_sub ? $signed({9'd0, w_sum[23]}) : r_exp + $signed({9'd0, w_sum[24]});
    assign w_ovf     = w_exp_fin >= 10'sd255;
    assign w_to_inf  = (r_rm == 2'b00) || ((r_rm == 2'b01) && r_sign) || ((r_rm == 2'b10) && !r_sign);

    always_comb begin
        w_result = {r_sign, w_exp_fin[7:0], w_sum[22:0]};
        if (w_ovf)
            w_result = w_to_inf ? {r_sign, 8'hFF, 23'd0} : {r_sign, 8'hFE, 23'h7FFFFF};
    end

    // ---------------- control ----------------
    // Special operands spend their single busy cycle in ROUND, which only registers the
    // value decoded at capture; the divide datapath is never used for them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sign     <= 1'b0;
            r_rm       <= 2'd0;
            r_special  <= 1'b0;
            r_spec_val <= 32'd0;
            r_div      <= 24'd0;
            r_rem      <= 25'd0;
            r_q        <= 26'd0;
            r_cnt      <= 5'd0;
            r_exp      <= 10'sd0;
            r_s        <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign     <= w_sign_in;
                        r_rm       <= rm;
                        r_special  <= w_special;
                        r_spec_val <= w_spec_val;
                        r_div      <= w_mb;
                        r_rem      <= w_a_lt ? {w_ma, 1'b0} : {1'b0, w_ma};
                        r_exp      <= w_a_lt ? w_exp_raw - 10'sd1 : w_exp_raw;
                        r_q        <= 26'd0;
                        r_cnt      <= 5'd25;
                        r_state    <= w_special ? ST_ROUND : ST_DIV;
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[24:0], w_ge};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0)
                        r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_s     <= r_special ? r_spec_val : w_result;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_DIV) || (r_state == ST_ROUND);
    assign done = (r_state == ST_DONE);
    assign s    = r_s;

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: self-checking bench for fdiv_seq, directed vectors plus random operands.
// Latency: expects done in cycle 28 (finite nonzero) or cycle 2 (specials) after the accepting edge.
// Backpressure: checks start is ignored while busy and in DONE, and that reset aborts a divide.
module tb_fdiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic        busy;
    logic        done;
    logic [31:0] s;

    int n_chk  = 0;
    int n_fail = 0;

    fdiv_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .rm    (rm),
        .busy  (busy),
        .done  (done),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int msb24(input int v);
        int m;
        m = 0;
        for (int i = 0; i < 24; i++)
            if (v[i]) m = i;
        return m;
    endfunction

    function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF) || (x[30:0] == 31'd0) || (y[30:0] == 31'd0);
    endfunction

    // Exact quotient by scaled integer division: value = M * 2^(E-150) for each operand,
    // result chosen as N * 2^(er-150) with N a 24-bit integer, plus guard/round/sticky.
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        logic         sg;
        int           ex, ey, ma, mb, ea, eb, da, db, t, er, p, n;
        bit           xn, yn, xi, yi, xz, yz, g, r, st, inc, to_inf;
        logic [127:0] num, den, q, rem;
        logic [7:0]   ef;
        logic [31:0]  nv;

        sg = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xz = (ex == 0) && (x[22:0] == 0);
        yz = (ey == 0) && (y[22:0] == 0);
        if (xn || yn || (xz && yz) || (xi && yi)) return 32'hFFC00000;
        if (yz || xi) return {sg, 8'hFF, 23'd0};
        if (xz || yi) return {sg, 31'd0};

        ma = int'(x[22:0]) + ((ex != 0) ? (1 << 23) : 0);
        mb = int'(y[22:0]) + ((ey != 0) ? (1 << 23) : 0);
        ea = (ex != 0) ? ex : 1;
        eb = (ey != 0) ? ey : 1;
        da = msb24(ma);
        db = msb24(mb);
        t  = da - db;
        if ((ma << (23 - da)) < (mb << (23 - db))) t = t - 1;
        er = ea - eb + 127 + t;
        if (er < 1) er = 1;
        p  = ea - eb + 150 - er + 2;
        if (p >= 0) begin
            num = 128'(ma) << p;
            den = 128'(mb);
        end else if (p < -60) begin
            num = 128'd0;
            den = 128'd1;
        end else begin
            num = 128'(ma);
            den = 128'(mb) << (-p);
        end
        q   = num / den;
        rem = num % den;
        st  = (rem != 0) || (p < -60);
        n   = int'(q >> 2);
        g   = q[1];
        r   = q[0];
        case (m)
            2'd0:    inc = g & (r | st | n[0]);
            2'd1:    inc = (g | r | st) & sg;
            2'd2:    inc = (g | r | st) & ~sg;
            default: inc = 1'b0;
        endcase
        n = n + int'(inc);
        if (n == (1 << 24)) begin
            n  = 1 << 23;
            er = er + 1;
        end
        if (er >= 255) begin
            to_inf = (m == 2'd0) || ((m == 2'd1) && sg) || ((m == 2'd2) && !sg);
            return to_inf ? {sg, 8'hFF, 23'd0} : {sg, 8'hFE, 23'h7FFFFF};
        end
        ef = (n >= (1 << 23)) ? 8'(er) : 8'd0;
        nv = 32'(n);
        return {sg, ef, nv[22:0]};
    endfunction

    // ---------------- one divide with timing checks ----------------
    // glitch: cycle number in which a stray start (with junk operands) is pulsed; 0 = none.
    task automatic run_div(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] trm,
                           input logic [31:0] exp_s, input int exp_lat, input int glitch);
        int cyc;
        int busy_bad;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb;
        rm    = trm;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_bad = 0;
        while (!done && cyc <= 40) begin
            if (!busy) busy_bad++;
            start = (cyc == glitch);
            if (cyc == glitch) begin
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("busy_while_running", 32'(busy_bad), 32'd0);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("quotient", s, exp_s);
        start = (cyc == glitch);
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        if (glitch == exp_lat)
            chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
    endtask

    // ---------------- random operand helper ----------------
    // mode 0: any bits; 1: mid exponents; 2: tiny exponents; 3: huge exponents.
    function automatic logic [31:0] rnd_op(input int mode);
        logic [31:0] v;
        v = $urandom;
        case (mode)
            1:       v[30:23] = 8'($urandom_range(100, 154));
            2:       v[30:23] = 8'($urandom_range(0, 20));
            3:       v[30:23] = 8'($urandom_range(200, 254));
            default: v = v;
        endcase
        return v;
    endfunction

    logic [31:0] d_a   [14] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                32'hBF800000, 32'h3F800000, 32'h00000000, 32'hFF800000, 32'h40000000,
                                32'h7F000000, 32'h7F000000, 32'h00800000, 32'h00000001};
    logic [31:0] d_b   [14] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000,
                                32'h40400000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h7F800000,
                                32'h3E800000, 32'h3E800000, 32'h40000000, 32'h3F000000};
    logic [1:0]  d_rm  [14] = '{2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0,
                                2'd0, 2'd3, 2'd0, 2'd0};
    logic [31:0] d_s   [14] = '{32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAB, 32'h3EAAAAAA,
                                32'hBEAAAAAB, 32'h7F800000, 32'hFFC00000, 32'hFF800000, 32'h00000000,
                                32'h7F800000, 32'h7F7FFFFF, 32'h00400000, 32'h00000002};
    int          d_lat [14] = '{28, 28, 28, 28, 28, 28, 2, 2, 2, 2, 28, 28, 28, 28};

    initial begin
        int          n_done;
        int          ma_mode, mb_mode;
        logic [31:0] ra, rb;
        logic [1:0]  rrm;

        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        rm    = 2'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_s", s, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_div(d_a[i], d_b[i], d_rm[i], d_s[i], d_lat[i], 0);

        // stray start mid-divide and in the DONE cycle
        run_div(32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 28, 5);
        run_div(32'h3F800000, 32'h40400000, 2'd3, 32'h3EAAAAAA, 28, 28);

        // reset in cycle 10 aborts the divide with no done pulse
        @(negedge clk);
        start = 1'b1;
        a     = 32'h3F800000;
        b     = 32'h40400000;
        rm    = 2'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_s", s, 32'd0);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        run_div(32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 28, 0);

        // start and rst together: reset wins
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'h40C00000;
        b     = 32'h40000000;
        @(negedge clk);
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_idle", {31'd0, busy | done}, 32'd0);

        // random operands against the model
        for (int i = 0; i < 160; i++) begin
            case (i % 4)
                0:       begin ma_mode = 1; mb_mode = 1; end
                1:       begin ma_mode = 2; mb_mode = 3; end
                2:       begin ma_mode = 3; mb_mode = 2; end
                default: begin ma_mode = 0; mb_mode = 0; end
            endcase
            ra  = rnd_op(ma_mode);
            rb  = rnd_op(mb_mode);
            rrm = 2'($urandom_range(0, 3));
            run_div(ra, rb, rrm, ref_div(ra, rb, rrm), is_special(ra, rb) ? 2 : 28, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
